// File: rtl/serial_rx.sv
// UART receiver for serial modes 1, 2 and 3: 16x oversampled, majority-voted
// bits, SBUF/RB8/RI loading with the multiprocessor (SM2) acceptance rule.
module serial_rx #(
    parameter int OVS       = 16,
    parameter int DATA_BITS = 8
) (
    input  logic                 system_clk_i,
    input  logic                 system_rst_i,
    input  logic                 serial_rx_br_tick_i,
    input  logic                 serial_rx_rxd_i,
    input  logic                 serial_rx_scon_sm0_i,
    input  logic                 serial_rx_scon_sm1_i,
    input  logic                 serial_rx_scon_sm2_i,
    input  logic                 serial_rx_scon_ren_i,
    input  logic                 serial_rx_ri_clr_i,
    output logic [DATA_BITS-1:0] serial_rx_sbuf_o,
    output logic                 serial_rx_rb8_o,
    output logic                 serial_rx_ri_o,
    output logic                 serial_rx_busy_o,
    output logic                 serial_rx_frame_err_o
);

    localparam int BCW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_BIT9  = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;

    // Three samples straddle the bit centre; the last one also closes the vote.
    localparam logic [3:0] T_SAMP_A = 4'(OVS / 2 - 1);
    localparam logic [3:0] T_SAMP_B = 4'(OVS / 2);
    localparam logic [3:0] T_DECIDE = 4'(OVS / 2 + 1);
    localparam logic [3:0] T_END    = 4'(OVS - 1);

    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_BITS - 1);

    logic                 rxd_meta_q, rxd_meta_d;
    logic                 rxd_sync_q, rxd_sync_d;
    logic                 rxd_prev_q, rxd_prev_d;
    logic [2:0]           state_q,    state_d;
    logic [3:0]           tcnt_q,     tcnt_d;
    logic [BCW-1:0]       bcnt_q,     bcnt_d;
    logic                 samp_a_q,   samp_a_d;
    logic                 samp_b_q,   samp_b_d;
    logic [DATA_BITS-1:0] shreg_q,    shreg_d;
    logic                 bit9_q,     bit9_d;
    logic [DATA_BITS-1:0] sbuf_q,     sbuf_d;
    logic                 rb8_q,      rb8_d;
    logic                 ri_q,       ri_d;
    logic                 ferr_q,     ferr_d;

    logic       rx_active;
    logic       nine_bit;
    logic       fall_edge;
    logic       at_samp_a;
    logic       at_samp_b;
    logic       at_decide;
    logic       at_end;
    logic       majority;
    logic       flag;
    logic       load_ok;

    always_comb begin
        rx_active = serial_rx_scon_ren_i & (serial_rx_scon_sm0_i | serial_rx_scon_sm1_i);
        nine_bit  = serial_rx_scon_sm0_i;
        fall_edge = rxd_prev_q & ~rxd_sync_q;
        at_samp_a = serial_rx_br_tick_i && (tcnt_q == T_SAMP_A);
        at_samp_b = serial_rx_br_tick_i && (tcnt_q == T_SAMP_B);
        at_decide = serial_rx_br_tick_i && (tcnt_q == T_DECIDE);
        at_end    = serial_rx_br_tick_i && (tcnt_q == T_END);
        majority  = (samp_a_q & samp_b_q) | (samp_a_q & rxd_sync_q) | (samp_b_q & rxd_sync_q);
        // In mode 1 the stop bit stands in for the ninth bit.
        flag      = nine_bit ? bit9_q : majority;
        load_ok   = ~ri_q & (~serial_rx_scon_sm2_i | flag);
    end

    always_comb begin
        rxd_meta_d = serial_rx_rxd_i;
        rxd_sync_d = rxd_meta_q;
        rxd_prev_d = rxd_sync_q;
        state_d    = state_q;
        tcnt_d     = tcnt_q;
        bcnt_d     = bcnt_q;
        samp_a_d   = samp_a_q;
        samp_b_d   = samp_b_q;
        shreg_d    = shreg_q;
        bit9_d     = bit9_q;
        sbuf_d     = sbuf_q;
        rb8_d      = rb8_q;
        ri_d       = ri_q;
        ferr_d     = 1'b0;

        if (serial_rx_ri_clr_i) begin
            ri_d = 1'b0;
        end

        if (serial_rx_br_tick_i) begin
            tcnt_d = tcnt_q + 4'd1;
        end
        if (at_samp_a) begin
            samp_a_d = rxd_sync_q;
        end
        if (at_samp_b) begin
            samp_b_d = rxd_sync_q;
        end

        if (!rx_active) begin
            state_d = S_IDLE;
            tcnt_d  = 4'd0;
            bcnt_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (fall_edge) begin
                        state_d = S_START;
                        tcnt_d  = 4'd0;
                        bcnt_d  = '0;
                    end
                end
                S_START: begin
                    if (at_decide && majority) begin
                        state_d = S_IDLE;
                    end else if (at_end) begin
                        state_d = S_DATA;
                        bcnt_d  = '0;
                    end
                end
                S_DATA: begin
                    if (at_decide) begin
                        shreg_d = {majority, shreg_q[DATA_BITS-1:1]};
                    end
                    if (at_end) begin
                        if (bcnt_q == LAST_BIT) begin
                            state_d = nine_bit ? S_BIT9 : S_STOP;
                            bcnt_d  = '0;
                        end else begin
                            bcnt_d = bcnt_q + BCW'(1);
                        end
                    end
                end
                S_BIT9: begin
                    if (at_decide) begin
                        bit9_d = majority;
                    end
                    if (at_end) begin
                        state_d = S_STOP;
                    end
                end
                S_STOP: begin
                    if (at_decide) begin
                        if (!majority) begin
                            ferr_d = 1'b1;
                        end else if (load_ok) begin
                            sbuf_d = shreg_q;
                            rb8_d  = flag;
                            ri_d   = 1'b1;
                        end
                        // Do not wait out the stop bit, so a start edge here re-arms at once.
                        if (fall_edge) begin
                            state_d = S_START;
                            tcnt_d  = 4'd0;
                            bcnt_d  = '0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge system_clk_i) begin
        if (system_rst_i) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            rxd_prev_q <= 1'b1;
            state_q    <= S_IDLE;
            tcnt_q     <= 4'd0;
            bcnt_q     <= '0;
            samp_a_q   <= 1'b1;
            samp_b_q   <= 1'b1;
            shreg_q    <= '0;
            bit9_q     <= 1'b0;
            sbuf_q     <= '0;
            rb8_q      <= 1'b0;
            ri_q       <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            rxd_meta_q <= rxd_meta_d;
            rxd_sync_q <= rxd_sync_d;
            rxd_prev_q <= rxd_prev_d;
            state_q    <= state_d;
            tcnt_q     <= tcnt_d;
            bcnt_q     <= bcnt_d;
            samp_a_q   <= samp_a_d;
            samp_b_q   <= samp_b_d;
            shreg_q    <= shreg_d;
            bit9_q     <= bit9_d;
            sbuf_q     <= sbuf_d;
            rb8_q      <= rb8_d;
            ri_q       <= ri_d;
            ferr_q     <= ferr_d;
        end
    end

    assign serial_rx_sbuf_o      = sbuf_q;
    assign serial_rx_rb8_o       = rb8_q;
    assign serial_rx_ri_o        = ri_q;
    assign serial_rx_busy_o      = (state_q != S_IDLE);
    assign serial_rx_frame_err_o = ferr_q;

endmodule
